// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot coordinate generator and calc wrapper:
// default fixed-point/address widths and the two-state FSM encoding.
package mandelbrot_pkg;

    localparam int FPW_DEFAULT = 54;
    localparam int AW_DEFAULT  = 11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mandelbrot_coord_gen.sv
// Walks a WIDTH x HEIGHT pixel grid in raster order and streams one
// fixed-point (x, y) coordinate plus linear pixel address per accepted beat.
//
// Handshake: a beat transfers on a clock edge where out_vld, out_rdy and
// clk_en are all 1; while out_vld=1 without a transfer, x_man/y_man/adr_o
// hold; out_rdy is ignored while out_vld=0. The output registers are the
// handshake registers themselves, so no extra skid stage sits in front.
module mandelbrot_coord_gen
    import mandelbrot_pkg::*;
#(
    parameter int FPW    = FPW_DEFAULT,
    parameter int AW     = AW_DEFAULT,
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 30
) (
    input  logic           clk,
    input  logic           clk_en,
    input  logic           rst,
    input  logic           start,
    input  logic [FPW-1:0] x0,
    input  logic [FPW-1:0] y0,
    input  logic [FPW-1:0] dx,
    input  logic [FPW-1:0] dy,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [FPW-1:0] x_man,
    output logic [FPW-1:0] y_man,
    output logic [AW-1:0]  adr_o,
    output logic           busy,
    output logic           done,
    output state_t         dbg_state
);

    localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    // The grid must fit in the address space.
    if (WIDTH * HEIGHT > 2 ** AW) begin : g_size_check
        $error("mandelbrot_coord_gen: WIDTH*HEIGHT exceeds 2**AW");
    end

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [FPW-1:0] x0_cap;
    logic [FPW-1:0] dx_cap;
    logic [FPW-1:0] dy_cap;
    logic           done_q;
    logic           xfer;
    logic           last_pix;

    assign xfer     = out_vld & out_rdy & clk_en;
    assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

    // State register; transitions are already qualified by clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept start only when idle, return to idle on the last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clk_en && start)  state_nxt = RUN;
            RUN:     if (xfer && last_pix) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs derived from the state plus the registered done pulse.
    always_comb begin
        out_vld   = (state == RUN);
        busy      = (state == RUN);
        done      = done_q;
        dbg_state = state;
    end

    // Coordinate/address datapath and the one-enabled-cycle done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_man  <= '0;
            y_man  <= '0;
            adr_o  <= '0;
            col    <= '0;
            row    <= '0;
            x0_cap <= '0;
            dx_cap <= '0;
            dy_cap <= '0;
            done_q <= 1'b0;
        end else if (clk_en) begin
            done_q <= xfer && last_pix;
            if (state == IDLE && start) begin
                x0_cap <= x0;
                dx_cap <= dx;
                dy_cap <= dy;
                x_man  <= x0;
                y_man  <= y0;
                adr_o  <= '0;
                col    <= '0;
                row    <= '0;
            end else if (xfer && !last_pix) begin
                adr_o <= adr_o + AW'(1);
                if (col != COL_LAST) begin
                    col   <= col + CW'(1);
                    x_man <= x_man + dx_cap;
                end else begin
                    col   <= '0;
                    row   <= row + RW'(1);
                    x_man <= x0_cap;
                    y_man <= y_man + dy_cap;
                end
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_coord_gen.sv
// Directed/randomized bench for mandelbrot_coord_gen on a 4x3 grid.
module tb_mandelbrot_coord_gen;
  import mandelbrot_pkg::*;

  localparam int FPW = 16;
  localparam int AW  = 4;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int N   = W * H;

  logic           clk = 1'b0;
  logic           clk_en;
  logic           rst;
  logic           start;
  logic [FPW-1:0] x0, y0, dx, dy;
  logic           out_vld;
  logic           out_rdy;
  logic [FPW-1:0] x_man, y_man;
  logic [AW-1:0]  adr_o;
  logic           busy;
  logic           done;
  state_t         dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected beats {adr, x, y} still to be transferred.
  logic [35:0] exp_q[$];

  // Clock/reset block
  always #5 clk = ~clk;

  mandelbrot_coord_gen #(
    .FPW(FPW), .AW(AW), .WIDTH(W), .HEIGHT(H)
  ) dut (
    .clk(clk), .clk_en(clk_en), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .dx(dx), .dy(dy),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .x_man(x_man), .y_man(y_man), .adr_o(adr_o),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: model builds the raster sequence arithmetically, the loop
  // drives ready/enable and compares every cycle against the queue head.
  task automatic run_frame(input logic [15:0] x0v, input logic [15:0] y0v,
                           input logic [15:0] dxv, input logic [15:0] dyv,
                           input int stall_pct, input bit en_toggle,
                           input int start_at, input int rst_at);
    int          cyc;
    logic [35:0] cur;
    logic [15:0] xe, ye;
    exp_q.delete();
    for (int p = 0; p < N; p++) begin
      xe = x0v + 16'(p % W) * dxv;
      ye = y0v + 16'(p / W) * dyv;
      exp_q.push_back({4'(p), xe, ye});
    end
    x0 = x0v; y0 = y0v; dx = dxv; dy = dyv;
    start = 1'b1; clk_en = 1'b1; out_rdy = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    x0 = 16'($urandom); y0 = 16'($urandom); dx = 16'($urandom); dy = 16'($urandom);
    chk("start_flags", {out_vld, busy, done}, 3'b110);
    chk("start_state", 64'(dbg_state), 64'(RUN));
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      cur = exp_q[0];
      chk("run_flags", {out_vld, busy, done}, 3'b110);
      chk("coord", {adr_o, x_man, y_man}, cur);
      if (rst_at >= 0 && int'(cur[35:32]) == rst_at) begin
        rst = 1'b1; clk_en = 1'($urandom_range(0, 1)); out_rdy = 1'b1;
        step();
        rst = 1'b0; clk_en = 1'b1;
        chk("rst_outputs", {out_vld, busy, done, adr_o, x_man, y_man}, 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(IDLE));
        repeat (3) begin
          step();
          chk("rst_no_done", {out_vld, busy, done}, 3'b000);
        end
        exp_q.delete();
        return;
      end
      clk_en  = en_toggle ? (cyc % 2 == 0) : 1'b1;
      out_rdy = ($urandom_range(0, 99) >= stall_pct);
      start   = (start_at >= 0 && int'(cur[35:32]) == start_at) || (exp_q.size() == 1);
      step();
      start = 1'b0;
      if (clk_en && out_rdy) void'(exp_q.pop_front());
      cyc++;
    end
    chk("timeout", 64'(exp_q.size()), 64'd0);
    if (stall_pct == 0 && !en_toggle) chk("throughput", 64'(cyc), 64'(N));
    chk("done_pulse", {out_vld, busy, done}, 3'b001);
    chk("done_state", 64'(dbg_state), 64'(IDLE));
    chk("done_adr", 64'(adr_o), 64'(N - 1));
    if (en_toggle) begin
      clk_en = 1'b0;
      repeat (2) begin
        step();
        chk("done_hold", {out_vld, busy, done}, 3'b001);
      end
    end
    clk_en = 1'b1; out_rdy = 1'b1;
    step();
    chk("done_clear", {out_vld, busy, done}, 3'b000);
  endtask

  initial begin
    clk_en = 1'b1; rst = 1'b1; start = 1'b0; out_rdy = 1'b0;
    x0 = '0; y0 = '0; dx = '0; dy = '0;
    step();
    step();
    chk("reset_outputs", {out_vld, busy, done, adr_o, x_man, y_man}, 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(IDLE));

    // ready while idle does nothing
    rst = 1'b0; out_rdy = 1'b1;
    repeat (3) step();
    chk("idle_rdy", {out_vld, busy, done, adr_o}, 64'd0);

    // reset wins over start
    rst = 1'b1; start = 1'b1; x0 = 16'h1234;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start", {out_vld, busy, x_man}, 64'd0);

    // full frame, no stalls
    run_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020, 0, 1'b0, -1, -1);
    // same frame under backpressure
    run_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020, 30, 1'b0, -1, -1);
    // ignored start mid-frame plus x wrap
    run_frame(16'hFFF0, 16'($urandom), 16'h0020, 16'($urandom), 0, 1'b0, 5, -1);
    // clk_en toggling during run and done
    run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b1, -1, -1);
    // reset mid-frame then clean restart
    run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, -1, 7);
    run_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020, 0, 1'b0, -1, -1);
    // random frames
    for (int k = 0; k < 4; k++) begin
      run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(0, 50), 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mandelbrot_coord_gen.md
MANDELBROT_COORD_GEN -- requirements
Module: mandelbrot_coord_gen

Interface
REQ-001 Parameter FPW, default 54: bitwidth of the two's-complement fixed-point coordinates and steps.
REQ-002 Parameter AW, default 11: pixel address width.
REQ-003 Parameter WIDTH, default 40: pixels per row.
REQ-004 Parameter HEIGHT, default 30: rows per frame; WIDTH*HEIGHT <= 2**AW, with an elaboration-time check.
REQ-005 clk  input  1  clock; one clock only.
REQ-006 clk_en  input  1  clock enable; the block's state advances only in cycles where clk_en=1.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 start  input  1  single-cycle frame start request.
REQ-009 x0, y0  input  FPW each  coordinates of pixel 0.
REQ-010 dx, dy  input  FPW each  signed column and row steps.
REQ-011 out_vld  output  1  coordinate valid; connects to the calc wrapper's in_vld.
REQ-012 out_rdy  input  1  downstream ready; connects to in_rdy.
REQ-013 x_man, y_man  output  FPW each  current coordinate.
REQ-014 adr_o  output  AW  linear pixel address; connects to adr_i.
REQ-015 busy  output  1  frame in progress.
REQ-016 done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-017 The FSM SHALL have two states: IDLE and RUN.
REQ-018 IDLE with start=1 and clk_en=1:
- capture x0, y0, dx, dy;
- load x_man=x0, y_man=y0, adr_o=0, col=0, row=0;
- enter RUN with out_vld=1 and busy=1 on the next cycle (latency 1).
REQ-019 start SHALL be ignored while in RUN; parameter inputs are sampled only at an accepted start.
REQ-020 A transfer occurs when out_vld & out_rdy & clk_en are all 1.
- x_man, y_man and adr_o SHALL stay stable while out_vld=1 and no transfer occurs.
REQ-021 On a transfer that is not the last pixel:
- adr_o += 1;
- if col < WIDTH-1: col += 1, x_man += dx;
- else: col=0, row += 1, x_man = captured x0, y_man += dy.
REQ-022 Arithmetic on x_man and y_man SHALL wrap modulo 2**FPW (no saturation); adr_o never exceeds WIDTH*HEIGHT-1.
REQ-023 With out_rdy held at 1 and clk_en held at 1, throughput SHALL be one coordinate per cycle, and a frame SHALL take exactly WIDTH*HEIGHT transfer cycles.
REQ-024 On the transfer of adr_o = WIDTH*HEIGHT-1:
- go to IDLE;
- next cycle: out_vld=0, busy=0, done=1 for exactly one cycle.
REQ-025 done SHALL be 0 at all other times; start asserted in the same cycle as the last transfer is ignored.
REQ-026 out_rdy=1 while out_vld=0 SHALL have no effect.
REQ-027 clk_en=0 SHALL freeze all state, outputs included; done stays high across clk_en=0 cycles until the next enabled cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL, regardless of clk_en:
- set the state to IDLE;
- set out_vld=0, busy=0, done=0;
- set adr_o=0, x_man=0, y_man=0, col=0, row=0.
REQ-029 rst SHALL override start in the same cycle.
REQ-030 rst in mid-frame SHALL abandon the frame with no done pulse.

Structure
REQ-031 The FPW and AW defaults and the state encoding (IDLE=0, RUN=1) SHALL live in shared package mandelbrot_pkg, which the calc wrapper also uses.
REQ-032 The column and row counters SHALL be $clog2(WIDTH) and $clog2(HEIGHT) bits wide (minimum 1) and be local to the block.
REQ-033 No sub-module SHALL be used; the output registers are the handshake registers, with no internal stream_reg.

Verification (bench parameters WIDTH=4, HEIGHT=3, FPW=16, AW=4)
REQ-034 Full frame with out_rdy=1:
- stimulus: start with x0=0x0100, y0=0x0200, dx=0x0010, dy=0x0020;
- response: 12 transfers on consecutive cycles; adr 0..11; x_man cycles 0x0100, 0x0110, 0x0120, 0x0130 per row; y_man 0x0200, 0x0220, 0x0240 per row; done pulses once, one cycle after adr 11.
REQ-035 Backpressure:
- stimulus: out_rdy randomly 0 for 30% of cycles;
- response: identical transfer sequence to REQ-034; data stable whenever out_vld=1 and out_rdy=0.
REQ-036 Ignored start and wrap:
- stimulus: start asserted at adr 5 carrying different x0; also x0=0xFFF0 with dx=0x0020;
- response: the frame is unaffected by the second start; x_man = 0xFFF0, 0x0010, 0x0030, 0x0050 on each row.
REQ-037 clk_en gating:
- stimulus: clk_en toggled 1,0,1,0 during RUN and during done;
- response: no state change in clk_en=0 cycles; done is seen for exactly one enabled cycle.
REQ-038 Reset mid-frame:
- stimulus: rst at adr 7;
- response: next cycle out_vld=0, busy=0, adr_o=0, no done; a new start restarts the frame at adr 0.
